ip_slot_bridge: RTL and testbench

IP_SLOT_BRIDGE -- requirements
Module: ip_slot_bridge

---
 rtl/ip_slot_bridge_pkg.sv | 16 +
 rtl/ip_slot_bridge_sync2.sv | 32 +++
 rtl/ip_slot_bridge.sv | 123 ++++++++++++
 tb/tb_ip_slot_bridge.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/ip_slot_bridge_pkg.sv
// Shared definitions for the cartridge-slot to MSX-50BUS bridge:
// FSM state encoding, read timeout limit and the byte returned when no device answers.
package ip_slot_bridge_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_HOLD = 3'd2,
        WR_REQ  = 3'd3,
        WR_HOLD = 3'd4
    } state_e;

    localparam logic [3:0] TIMEOUT_LIMIT  = 4'd15;
    localparam logic [7:0] NO_DEVICE_BYTE = 8'hFF;

endpackage

// File: rtl/ip_slot_bridge_sync2.sv
// Two-flop synchronizer for one asynchronous slot strobe; resets to RESET_VAL
// so an active-low strobe reads as inactive straight out of reset.
module ip_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic n_reset,
    input  logic d,
    output logic q
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/ip_slot_bridge.sv
// Bridges MSX cartridge-slot memory strobes onto one MSX-50BUS request per access.
// Define IP_SLOT_BRIDGE_WAIT_EN to drive n_wait low while a read is outstanding.
module ip_slot_bridge
    import ip_slot_bridge_pkg::*;
(
    input  logic        clk,
    input  logic        n_reset,
    input  logic [15:0] slot_a,
    input  logic [7:0]  slot_d_in,
    output logic [7:0]  slot_d_out,
    output logic        slot_d_oe,
    input  logic        n_sltsl,
    input  logic        n_merq,
    input  logic        n_rd,
    input  logic        n_wr,
    output logic        n_wait,
    output logic [15:0] bus_address,
    output logic [7:0]  bus_write_data,
    output logic        bus_memory_read,
    output logic        bus_memory_write,
    input  logic        bus_read_ready,
    input  logic [7:0]  bus_read_data
);

    logic s_sltsl, s_merq, s_rd, s_wr;

    ip_sync2 #(.RESET_VAL(1'b1)) u_sync_sltsl (.clk(clk), .n_reset(n_reset), .d(n_sltsl), .q(s_sltsl));
    ip_sync2 #(.RESET_VAL(1'b1)) u_sync_merq  (.clk(clk), .n_reset(n_reset), .d(n_merq),  .q(s_merq));
    ip_sync2 #(.RESET_VAL(1'b1)) u_sync_rd    (.clk(clk), .n_reset(n_reset), .d(n_rd),    .q(s_rd));
    ip_sync2 #(.RESET_VAL(1'b1)) u_sync_wr    (.clk(clk), .n_reset(n_reset), .d(n_wr),    .q(s_wr));

    state_e      state_q, state_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [7:0]  rdata_q, rdata_d;
    logic [3:0]  timeout_q, timeout_d;

    // Both strobes low together is a conflicting access and is ignored.
    logic rd_detect, wr_detect;
    assign rd_detect = !s_sltsl && !s_merq && !s_rd &&  s_wr;
    assign wr_detect = !s_sltsl && !s_merq &&  s_rd && !s_wr;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        timeout_d = timeout_q;

        case (state_q)
            IDLE: begin
                if (rd_detect) begin
                    addr_d    = slot_a;
                    timeout_d = 4'd0;
                    state_d   = RD_REQ;
                end else if (wr_detect) begin
                    addr_d  = slot_a;
                    wdata_d = slot_d_in;
                    state_d = WR_REQ;
                end
            end
            RD_REQ: begin
                // Counter holds cycles already spent here, so the last one is LIMIT-1.
                if (bus_read_ready) begin
                    rdata_d = bus_read_data;
                    state_d = RD_HOLD;
                end else if (timeout_q == TIMEOUT_LIMIT - 4'd1) begin
                    rdata_d = NO_DEVICE_BYTE;
                    state_d = RD_HOLD;
                end else begin
                    timeout_d = timeout_q + 4'd1;
                end
            end
            RD_HOLD: begin
                if (s_rd) begin
                    state_d = IDLE;
                end
            end
            WR_REQ: begin
                state_d = WR_HOLD;
            end
            WR_HOLD: begin
                if (s_wr) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state_q   <= IDLE;
            addr_q    <= 16'h0000;
            wdata_q   <= 8'h00;
            rdata_q   <= 8'h00;
            timeout_q <= 4'd0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus_address      = addr_q;
    assign bus_write_data   = wdata_q;
    assign bus_memory_read  = (state_q == RD_REQ);
    assign bus_memory_write = (state_q == WR_REQ);
    assign slot_d_out       = rdata_q;
    // Released combinationally so the driver is off in the cycle s_rd returns high.
    assign slot_d_oe        = (state_q == RD_HOLD) && !s_rd;

`ifdef IP_SLOT_BRIDGE_WAIT_EN
    assign n_wait = !(n_reset && (((state_q == IDLE) && rd_detect) || (state_q == RD_REQ)));
`else
    assign n_wait = 1'b1;
`endif

endmodule

// File: tb/tb_ip_slot_bridge.sv
// Directed and randomized checks of ip_slot_bridge against a RAM-style bus device
// and a reference memory kept in the bench.
module tb_ip_slot_bridge;

    logic        clk;
    logic        n_reset;
    logic [15:0] slot_a;
    logic [7:0]  slot_d_in;
    logic [7:0]  slot_d_out;
    logic        slot_d_oe;
    logic        n_sltsl, n_merq, n_rd, n_wr;
    logic        n_wait;
    logic [15:0] bus_address;
    logic [7:0]  bus_write_data;
    logic        bus_memory_read, bus_memory_write;
    logic        bus_read_ready;
    logic [7:0]  bus_read_data;

    ip_slot_bridge dut (
        .clk(clk), .n_reset(n_reset),
        .slot_a(slot_a), .slot_d_in(slot_d_in), .slot_d_out(slot_d_out), .slot_d_oe(slot_d_oe),
        .n_sltsl(n_sltsl), .n_merq(n_merq), .n_rd(n_rd), .n_wr(n_wr), .n_wait(n_wait),
        .bus_address(bus_address), .bus_write_data(bus_write_data),
        .bus_memory_read(bus_memory_read), .bus_memory_write(bus_memory_write),
        .bus_read_ready(bus_read_ready), .bus_read_data(bus_read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Device RAM (written only by bus writes) and the bench's expected memory image.
    logic [7:0] dev_mem [logic [15:0]];
    logic [7:0] ref_mem [logic [15:0]];

    function automatic logic [7:0] power_on_byte(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'hDA;
    endfunction

    int   rd_rises = 0, wr_rises = 0, rd_high_cyc = 0, wait_low_cyc = 0, proto_viol = 0;
    logic rd_prev = 1'b0, wr_prev = 1'b0;
    bit   responder_en = 1'b1;
    bit   addr_chk_en = 1'b0;
    bit   pending = 1'b0;
    int   lat = 0;
    logic [15:0] cur_addr = 16'h0;

    // Bus device plus protocol monitor, sampling on the falling edge.
    always @(negedge clk) begin
        if (bus_memory_read && !rd_prev) rd_rises++;
        if (bus_memory_write && !wr_prev) wr_rises++;
        if (bus_memory_write && wr_prev) proto_viol++;
        if (bus_memory_read) rd_high_cyc++;
        if (!n_wait) wait_low_cyc++;
        if (slot_d_oe && (bus_memory_read || bus_memory_write)) proto_viol++;
        if (addr_chk_en && (bus_memory_read || bus_memory_write || slot_d_oe) && bus_address !== cur_addr)
            proto_viol++;
        if (bus_memory_write) dev_mem[bus_address] = bus_write_data;
        bus_read_ready = 1'b0;
        bus_read_data  = 8'h00;
        if (!n_reset) begin
            pending = 1'b0;
        end else if (pending) begin
            lat--;
            if (lat == 0) begin
                bus_read_ready = 1'b1;
                bus_read_data  = dev_mem.exists(bus_address) ? dev_mem[bus_address] : power_on_byte(bus_address);
                pending = 1'b0;
            end
        end else if (bus_memory_read && !rd_prev && responder_en) begin
            pending = 1'b1;
            lat = int'($urandom_range(1, 6));
        end
        rd_prev = bus_memory_read;
        wr_prev = bus_memory_write;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] expected_byte(input logic [15:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : power_on_byte(a);
    endfunction

    task automatic slot_read(input logic [15:0] addr, input logic [7:0] exp, input int exp_req_cyc);
        int rr0, rh0, wl0, n;
        rr0 = rd_rises; rh0 = rd_high_cyc; wl0 = wait_low_cyc;
        cur_addr = addr;
        slot_a = addr; n_sltsl = 1'b0; n_merq = 1'b0; n_rd = 1'b0;
        n = 0;
        while (!slot_d_oe && n < 60) begin
            tick();
            if (rd_rises != rr0) slot_a = ~addr;
            n++;
        end
        check("rd_oe_seen", 32'(slot_d_oe), 32'd1);
        check("rd_data", 32'(slot_d_out), 32'(exp));
        repeat (3) tick();
        check("rd_hold", {23'd0, slot_d_oe, slot_d_out}, {23'd0, 1'b1, exp});
        n_rd = 1'b1; n_sltsl = 1'b1; n_merq = 1'b1;
        repeat (3) tick();
        check("rd_oe_release", 32'(slot_d_oe), 32'd0);
        check("rd_one_request", 32'(rd_rises - rr0), 32'd1);
        if (exp_req_cyc > 0) check("rd_timeout_cycles", 32'(rd_high_cyc - rh0), 32'(exp_req_cyc));
`ifdef IP_SLOT_BRIDGE_WAIT_EN
        check("rd_wait_len", 32'(wait_low_cyc - wl0), 32'(rd_high_cyc - rh0 + 1));
`else
        check("rd_wait_len", 32'(wait_low_cyc - wl0), 32'd0);
`endif
        tick();
    endtask

    task automatic slot_write(input logic [15:0] addr, input logic [7:0] data);
        int wr0, wl0, n;
        wr0 = wr_rises; wl0 = wait_low_cyc;
        cur_addr = addr;
        slot_a = addr; slot_d_in = data; n_sltsl = 1'b0; n_merq = 1'b0; n_wr = 1'b0;
        n = 0;
        while (!bus_memory_write && n < 40) begin
            tick();
            n++;
        end
        check("wr_pulse_seen", 32'(bus_memory_write), 32'd1);
        check("wr_addr", 32'(bus_address), 32'(addr));
        check("wr_data", 32'(bus_write_data), 32'(data));
        slot_a = ~addr; slot_d_in = ~data;
        tick();
        check("wr_one_cycle", 32'(bus_memory_write), 32'd0);
        n_wr = 1'b1; n_sltsl = 1'b1; n_merq = 1'b1;
        repeat (3) tick();
        check("wr_one_request", 32'(wr_rises - wr0), 32'd1);
        check("wr_wait_len", 32'(wait_low_cyc - wl0), 32'd0);
        ref_mem[addr] = data;
        tick();
    endtask

    initial begin
        int rr0, wr0, oe_cyc, n;
        logic [15:0] ra;
        logic [7:0]  rd8;
        n_reset = 1'b0;
        slot_a = 16'h0; slot_d_in = 8'h0;
        n_sltsl = 1'b1; n_merq = 1'b1; n_rd = 1'b1; n_wr = 1'b1;
        bus_read_ready = 1'b0; bus_read_data = 8'h0;
        repeat (3) tick();
        check("reset_state",
              {bus_address, bus_write_data, bus_memory_read, bus_memory_write, slot_d_oe, n_wait},
              {16'h0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1});
        check("reset_d_out", 32'(slot_d_out), 32'd0);
        n_reset = 1'b1;
        tick();
        addr_chk_en = 1'b1;

        slot_read(16'h8000, 8'h5A, 0);
        slot_write(16'h8001, 8'h3C);
        slot_read(16'h8001, 8'h3C, 0);

        responder_en = 1'b0;
        slot_read(16'h0000, 8'hFF, 15);
        responder_en = 1'b1;

        // Read and write strobes low together: no access at all.
        rr0 = rd_rises; wr0 = wr_rises; oe_cyc = 0;
        slot_a = 16'h8000; n_sltsl = 1'b0; n_merq = 1'b0; n_rd = 1'b0; n_wr = 1'b0;
        repeat (10) begin
            tick();
            if (slot_d_oe) oe_cyc++;
        end
        n_sltsl = 1'b1; n_merq = 1'b1; n_rd = 1'b1; n_wr = 1'b1;
        repeat (3) tick();
        check("conflict_no_pulse", 32'((rd_rises - rr0) + (wr_rises - wr0)), 32'd0);
        check("conflict_no_oe", 32'(oe_cyc), 32'd0);

        // Reset in the middle of a read request.
        cur_addr = 16'h8000;
        slot_a = 16'h8000; n_sltsl = 1'b0; n_merq = 1'b0; n_rd = 1'b0;
        n = 0;
        while (!bus_memory_read && n < 30) begin
            tick();
            n++;
        end
        check("rst_req_seen", 32'(bus_memory_read), 32'd1);
        n_reset = 1'b0;
        tick();
        check("rst_mid_outputs",
              {bus_address, bus_write_data, bus_memory_read, bus_memory_write, slot_d_oe, n_wait},
              {16'h0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1});
        check("rst_mid_d_out", 32'(slot_d_out), 32'd0);
        rr0 = rd_rises;
        n_sltsl = 1'b1; n_merq = 1'b1; n_rd = 1'b1;
        repeat (3) tick();
        n_reset = 1'b1;
        repeat (3) tick();
        check("rst_no_new_request", 32'(rd_rises - rr0), 32'd0);
        slot_read(16'h8000, expected_byte(16'h8000), 0);

        for (int i = 0; i < 6; i++) begin
            ra  = 16'($urandom_range(1, 65535));
            rd8 = 8'($urandom);
            if ($urandom_range(0, 1) == 1) slot_write(ra, rd8);
            slot_read(ra, expected_byte(ra), 0);
        end

        check("protocol_monitor", 32'(proto_viol), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
